// File: rtl/shift_pkg.sv
// Shared types and widths for the pipelined shift/rotate unit.
// Rotate support is gated by the SHIFT_PIPE_ROL_EN macro in the consuming files.
package shift_pkg;

    localparam int SHIFT_W     = 16;
    localparam int SHIFT_AMT_W = 4;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROL = 2'b11
    } shift_op_t;

endpackage

// File: rtl/shift_stage.sv
// One fixed-distance level of the logarithmic shifter; purely combinational.
// Rotate wrap is built only when SHIFT_PIPE_ROL_EN is defined.
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned DIST = 1
) (
    input  logic [SHIFT_W-1:0] in_data,
    input  logic               en,
    input  shift_op_t          op,
    input  logic               fill,
    output logic [SHIFT_W-1:0] out_data
);

    always_comb begin
        out_data = in_data;
        if (en) begin
            case (op)
                SHIFT_SLL: out_data = {in_data[SHIFT_W-1-DIST:0], {DIST{1'b0}}};
                SHIFT_SRL: out_data = {{DIST{1'b0}}, in_data[SHIFT_W-1:DIST]};
                // fill carries the original operand's sign, not this level's MSB
                SHIFT_SRA: out_data = {{DIST{fill}}, in_data[SHIFT_W-1:DIST]};
                SHIFT_ROL: begin
`ifdef SHIFT_PIPE_ROL_EN
                    out_data = {in_data[SHIFT_W-1-DIST:0], in_data[SHIFT_W-1:SHIFT_W-DIST]};
`else
                    out_data = {in_data[SHIFT_W-1-DIST:0], {DIST{1'b0}}};
`endif
                end
                default:   out_data = in_data;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Two-stage 16-bit shift/rotate unit with valid/ready on both sides.
// Define SHIFT_PIPE_ROL_EN to enable rotate-left on op 2'b11 (otherwise it is SLL).
module shift_pipe
    import shift_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SHIFT_W-1:0]     in_data,
    input  logic [SHIFT_AMT_W-1:0] in_amt,
    input  logic [1:0]             in_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SHIFT_W-1:0]     out_data
);

    logic               r_s1_valid;
    logic [SHIFT_W-1:0] r_s1_data;
    logic [1:0]         r_s1_amt;
    shift_op_t          r_s1_op;
    logic               r_s1_sign;

    logic               r_out_valid;
    logic [SHIFT_W-1:0] r_out_data;

    shift_op_t          w_in_op;
    logic [SHIFT_W-1:0] w_lvl1;
    logic [SHIFT_W-1:0] w_lvl2;
    logic [SHIFT_W-1:0] w_lvl4;
    logic [SHIFT_W-1:0] w_lvl8;
    logic               w_s2_load;
    logic               w_s1_load;
    logic               w_in_xfer;

    always_comb begin
        w_in_op = shift_op_t'(in_op);
`ifndef SHIFT_PIPE_ROL_EN
        if (w_in_op == SHIFT_ROL) begin
            w_in_op = SHIFT_SLL;
        end
`endif
    end

    // Stage 2 may accept whenever its content leaves; stage 1 follows it.
    assign w_s2_load = !r_out_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign w_in_xfer = in_valid && w_s1_load;
    assign in_ready  = w_s1_load;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    shift_stage #(.DIST(1)) u_lvl1 (
        .in_data  (in_data),
        .en       (in_amt[0]),
        .op       (w_in_op),
        .fill     (in_data[SHIFT_W-1]),
        .out_data (w_lvl1)
    );

    shift_stage #(.DIST(2)) u_lvl2 (
        .in_data  (w_lvl1),
        .en       (in_amt[1]),
        .op       (w_in_op),
        .fill     (in_data[SHIFT_W-1]),
        .out_data (w_lvl2)
    );

    shift_stage #(.DIST(4)) u_lvl4 (
        .in_data  (r_s1_data),
        .en       (r_s1_amt[0]),
        .op       (r_s1_op),
        .fill     (r_s1_sign),
        .out_data (w_lvl4)
    );

    shift_stage #(.DIST(8)) u_lvl8 (
        .in_data  (w_lvl4),
        .en       (r_s1_amt[1]),
        .op       (r_s1_op),
        .fill     (r_s1_sign),
        .out_data (w_lvl8)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_amt   <= '0;
            r_s1_op    <= SHIFT_SLL;
            r_s1_sign  <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= w_in_xfer;
            if (w_in_xfer) begin
                r_s1_data <= w_lvl2;
                r_s1_amt  <= in_amt[3:2];
                r_s1_op   <= w_in_op;
                r_s1_sign <= in_data[SHIFT_W-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_lvl8;
            end
        end
    end

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed cases, stall, reset and random stream.
// Expected rotate results follow SHIFT_PIPE_ROL_EN as defined for the build.
module tb_shift_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shift_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] a,
                                              input logic [1:0] op);
        logic signed [15:0] s;
        logic [31:0]        dd;
        s  = d;
        dd = {d, d} << a;
        case (op)
            2'd0:    return d << a;
            2'd1:    return d >> a;
            2'd2:    return s >>> a;
`ifdef SHIFT_PIPE_ROL_EN
            default: return dd[31:16];
`else
            default: return d << a;
`endif
        endcase
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        vectors++;
        if (out_data !== 16'h0000) begin
            miscompares++; $display("FAIL reset_out_data got %h want 0000", out_data);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [15:0] d_tab [12];
        logic [3:0]  a_tab [12];
        logic [1:0]  o_tab [12];
        logic [15:0] e_tab [12];
        d_tab = '{16'h0001, 16'h8000, 16'hF000, 16'h8000, 16'h8001, 16'h8000,
                  16'h1235, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h00F0};
        a_tab = '{4'd15, 4'd4, 4'd12, 4'd15, 4'd1, 4'd15, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4};
        o_tab = '{2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
`ifdef SHIFT_PIPE_ROL_EN
        e_tab = '{16'h8000, 16'hF800, 16'h000F, 16'h0001, 16'h0003, 16'hFFFF,
                  16'h8000, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h000F};
`else
        e_tab = '{16'h8000, 16'hF800, 16'h000F, 16'h0001, 16'h0002, 16'hFFFF,
                  16'h8000, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h000F};
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_data = d_tab[i]; in_amt = a_tab[i]; in_op = o_tab[i];
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++; $display("FAIL dir%0d_in_ready got %b want 1", i, in_ready);
            end
            step();
            in_valid = 1'b0;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++; $display("FAIL dir%0d_early_valid got %b want 0", i, out_valid);
            end
            step();
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== e_tab[i]) begin
                miscompares++;
                $display("FAIL dir%0d_result got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, e_tab[i]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back;
        int idx = 0;
        int got = 0;
        bit acc;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 4); in_data = 16'h0001; in_amt = 4'(idx); in_op = 2'd0;
            @(negedge clk);
            acc = in_valid && in_ready;
            if (c >= 2) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== 16'h0001) begin
                    miscompares++;
                    $display("FAIL stall_hold c%0d got v=%b d=%h want v=1 d=0001", c, out_valid, out_data);
                end
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++; $display("FAIL stall_in_ready c%0d got %b want 0", c, in_ready);
                end
            end
            step();
            if (acc) idx++;
        end
        vectors++;
        if (idx != 2) begin
            miscompares++; $display("FAIL stall_accepted got %0d want 2", idx);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            in_valid = (idx < 4); in_amt = 4'(idx);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                vectors++;
                if (out_data !== (16'h0001 << got)) begin
                    miscompares++;
                    $display("FAIL b2b_order #%0d got %h want %h", got, out_data, 16'h0001 << got);
                end
                got++;
            end
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        vectors++;
        if (got != 4) begin
            miscompares++; $display("FAIL b2b_count got %0d want 4", got);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL b2b_duplicate got out_valid %b want 0", out_valid);
        end
        step();
    endtask

    task automatic test_reset_midstall;
        int outs = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; in_data = 16'h0001; in_amt = 4'(5 + c); in_op = 2'd0;
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_prefill got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_async got v=%b d=%h rdy=%b want v=0 d=0000 rdy=1", out_valid, out_data, in_ready);
        end
        step();
        step();
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 16'h00F0; in_amt = 4'd4; in_op = 2'd1; out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_first_ready got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) begin
                outs++;
                vectors++;
                if (out_data !== 16'h000F) begin
                    miscompares++; $display("FAIL rst_after got %h want 000F", out_data);
                end
            end
            step();
        end
        vectors++;
        if (outs != 1) begin
            miscompares++; $display("FAIL rst_result_count got %0d want 1", outs);
        end
    endtask

    task automatic test_random_stream;
        logic [15:0] exp_q[$];
        logic [15:0] want;
        logic [15:0] prev_data = '0;
        bit          prev_stall = 0;
        int          sent = 0;
        int          inflight = 0;
        int          cyc = 0;
        bit          xin;
        bit          xout;
        bit          pending = 0;
        while ((sent < 300 || inflight > 0) && cyc < 5000) begin
            if (!pending) begin
                if (sent < 300 && $urandom_range(0, 9) < 8) begin
                    in_valid = 1'b1;
                    in_data  = 16'($urandom);
                    in_amt   = 4'($urandom_range(0, 15));
                    in_op    = 2'($urandom_range(0, 3));
                    pending  = 1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            vectors++;
            if (in_ready !== ((inflight < 2) || out_ready)) begin
                miscompares++;
                $display("FAIL rnd_in_ready cyc%0d got %b inflight=%0d out_ready=%b", cyc, in_ready, inflight, out_ready);
            end
            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    miscompares++;
                    $display("FAIL rnd_hold cyc%0d got v=%b d=%h want v=1 d=%h", cyc, out_valid, out_data, prev_data);
                end
            end
            xin  = in_valid && in_ready;
            xout = out_valid && out_ready;
            if (xout) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL rnd_spurious cyc%0d got %h want none", cyc, out_data);
                end else begin
                    want = exp_q.pop_front();
                    if (out_data !== want) begin
                        miscompares++; $display("FAIL rnd_data cyc%0d got %h want %h", cyc, out_data, want);
                    end
                end
                inflight--;
            end
            if (xin) begin
                exp_q.push_back(ref_shift(in_data, in_amt, in_op));
                inflight++;
                sent++;
                pending = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        vectors++;
        if (sent != 300 || inflight != 0) begin
            miscompares++;
            $display("FAIL rnd_timeout got sent=%0d inflight=%0d want sent=300 inflight=0", sent, inflight);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstall();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
